// File: rtl/ifmap_window_feeder.sv
// Purpose  : PE-side ifmap FIFO consumer; keeps a FILT_W-deep sliding window of one
//            ifmap row and replays it, element by element, to the MAC datapath.
// Latency  : unstalled row takes FILT_W + num_win*FILT_W + (num_win-1) + 1 cycles after start.
// Backpress: out_ready=0 freezes the EMIT stream; fifo_empty=1 stalls FILL/SHIFT indefinitely.
//
// Ports:
//   clk, rst            clock (rising edge) and synchronous active-high reset
//   start, cfg_row_len  row request and its length W (sampled only in IDLE)
//   fifo_empty,
//   fifo_read_data,
//   fifo_read_en        first-word fall-through FIFO read side; read_en is combinational
//   out_data, out_valid,
//   out_ready, out_last window element stream to the MAC; out_last tags each window's end
//   busy, row_done,
//   cfg_err             status: not IDLE / one-cycle row completion / one-cycle start reject
module ifmap_window_feeder #(
  parameter int DATA_WIDTH = 16,
  parameter int FILT_W     = 3,
  parameter int LEN_W      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [LEN_W-1:0]      cfg_row_len,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_read_data,
  output logic                  fifo_read_en,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  busy,
  output logic                  row_done,
  output logic                  cfg_err
);

  localparam int CNT_W = $clog2(FILT_W + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FILT_W - 1);
  localparam logic [LEN_W-1:0] FILT_W_L = LEN_W'(FILT_W);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_EMIT,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t                state;
  logic [CNT_W-1:0]      fill_cnt;
  logic [CNT_W-1:0]      emit_idx;
  logic [LEN_W-1:0]      win_cnt;
  logic [LEN_W-1:0]      row_len;
  logic [DATA_WIDTH-1:0] win [FILT_W];

  logic pop;
  logic xfer;
  logic last_win;

  // Reads and transfers are suppressed in the reset cycle so an abort never
  // consumes a FIFO word or hands a stale element to the MAC.
  assign fifo_read_en = !rst && !fifo_empty && ((state == S_FILL) || (state == S_SHIFT));
  assign pop          = fifo_read_en;

  assign out_valid = !rst && (state == S_EMIT);
  assign out_last  = out_valid && (emit_idx == LAST_IDX);
  assign xfer      = out_valid && out_ready;

  assign busy     = (state != S_IDLE);
  assign row_done = (state == S_DONE);

  // num_win - 1 == row_len - FILT_W; row_len >= FILT_W is guaranteed at start,
  // so this never underflows.
  assign last_win = (win_cnt == (row_len - FILT_W_L));

  // Window element selected by the replay index.
  always_comb begin
    out_data = '0;
    for (int i = 0; i < FILT_W; i++) begin
      if (emit_idx == CNT_W'(i)) begin
        out_data = win[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      fill_cnt <= '0;
      emit_idx <= '0;
      win_cnt  <= '0;
      row_len  <= '0;
      cfg_err  <= 1'b0;
      for (int i = 0; i < FILT_W; i++) begin
        win[i] <= '0;
      end
    end else begin
      cfg_err <= 1'b0;

      case (state)
        S_IDLE: begin
          if (start) begin
            // A row shorter than the filter yields no window at all.
            if (cfg_row_len < FILT_W_L) begin
              cfg_err <= 1'b1;
            end else begin
              row_len  <= cfg_row_len;
              fill_cnt <= '0;
              emit_idx <= '0;
              win_cnt  <= '0;
              state    <= S_FILL;
            end
          end
        end

        S_FILL: begin
          if (pop) begin
            for (int i = 0; i < FILT_W; i++) begin
              if (fill_cnt == CNT_W'(i)) begin
                win[i] <= fifo_read_data;
              end
            end
            fill_cnt <= fill_cnt + CNT_W'(1);
            if (fill_cnt == LAST_IDX) begin
              state <= S_EMIT;
            end
          end
        end

        S_EMIT: begin
          if (xfer) begin
            if (emit_idx == LAST_IDX) begin
              emit_idx <= '0;
              state    <= last_win ? S_DONE : S_SHIFT;
            end else begin
              emit_idx <= emit_idx + CNT_W'(1);
            end
          end
        end

        S_SHIFT: begin
          // Stride 1: drop the oldest element, append exactly one new one.
          if (pop) begin
            for (int i = 0; i < FILT_W - 1; i++) begin
              win[i] <= win[i+1];
            end
            win[FILT_W-1] <= fifo_read_data;
            win_cnt       <= win_cnt + LEN_W'(1);
            state         <= S_EMIT;
          end
        end

        S_DONE: begin
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ifmap_window_feeder.sv
// Purpose  : self-checking bench for ifmap_window_feeder with a queue-based FIFO model
//            and a scoreboard fed from a window-level reference model.
// Latency  : n/a (bench).
// Backpress: drives fifo_empty and out_ready stalls, directed and random.
module tb_ifmap_window_feeder;

  localparam int DW = 16;
  localparam int FW = 3;
  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [LW-1:0] cfg_row_len;
  logic          fifo_empty;
  logic [DW-1:0] fifo_read_data;
  logic          fifo_read_en;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic          busy;
  logic          row_done;
  logic          cfg_err;

  always #5 clk = ~clk;

  ifmap_window_feeder #(
    .DATA_WIDTH(DW),
    .FILT_W    (FW),
    .LEN_W     (LW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .cfg_row_len   (cfg_row_len),
    .fifo_empty    (fifo_empty),
    .fifo_read_data(fifo_read_data),
    .fifo_read_en  (fifo_read_en),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_last      (out_last),
    .busy          (busy),
    .row_done      (row_done),
    .cfg_err       (cfg_err)
  );

  typedef struct {
    logic [DW-1:0] d;
    logic          l;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] fq[$];
  int            pop_cyc[$];

  int   n_checks = 0;
  int   n_fail   = 0;
  int   xfer_cnt = 0;
  int   cyc      = 0;
  logic force_empty;
  logic s_pop, s_done, s_busy, s_err;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    n_checks++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, got, req, cyc);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  exp_t          e;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_d;
  logic          prev_l;

  always @(negedge clk) begin
    #2;
    if (!rst && out_valid) begin
      if (prev_stall) begin
        check("hold_out_data", out_data, prev_d);
        check("hold_out_last", out_last, prev_l);
      end
      if (out_ready) begin
        xfer_cnt++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_output: got data %0h with nothing expected", out_data);
        end else begin
          e = exp_q.pop_front();
          check("out_data", out_data, e.d);
          check("out_last", out_last, e.l);
        end
      end
    end
    prev_stall = !rst && out_valid && !out_ready;
    prev_d     = out_data;
    prev_l     = out_last;
  end

  // ---------------- FIFO model and cycle stepping ----------------
  // Called at a negedge with this cycle's inputs set; returns at the next negedge
  // after retiring any pop the DUT performed on the intervening posedge.
  task automatic step();
    fifo_empty     = force_empty || (fq.size() == 0);
    fifo_read_data = (fq.size() != 0) ? fq[0] : '0;
    #1;
    if (fifo_empty) check("rd_en_while_empty", fifo_read_en, 0);
    if (rst) begin
      check("rst_cycle_rd_en", fifo_read_en, 0);
      check("rst_cycle_valid", out_valid, 0);
    end
    s_pop  = fifo_read_en && !fifo_empty;
    s_done = row_done;
    s_busy = busy;
    s_err  = cfg_err;
    if (s_pop) pop_cyc.push_back(cyc);
    @(negedge clk);
    if (s_pop) void'(fq.pop_front());
  endtask

  task automatic check_idle();
    fifo_empty     = (fq.size() == 0);
    fifo_read_data = (fq.size() != 0) ? fq[0] : '0;
    #1;
    check("idle_out_valid", out_valid, 0);
    check("idle_out_last", out_last, 0);
    check("idle_busy", busy, 0);
    check("idle_row_done", row_done, 0);
    check("idle_cfg_err", cfg_err, 0);
    check("idle_rd_en", fifo_read_en, 0);
    check("idle_out_data", out_data, 0);
    @(negedge clk);
  endtask

  // ---------------- one row: stimulus + reference model ----------------
  task automatic run_row(input int w, input int data_mode, input int ready_mode,
                         input int empty_mode, input int rst_at, input int start2_at,
                         input int exp_done, input bit chk_pops);
    logic [DW-1:0] d[$];
    int x0;
    int done_cyc;
    logic busy_at_done;
    int exp_pc;
    fq.delete();
    pop_cyc.delete();
    for (int i = 0; i < w; i++) begin
      d.push_back(data_mode != 0 ? DW'($urandom_range(0, 65535)) : DW'(i + 1));
      fq.push_back(d[i]);
    end
    fq.push_back(16'hDEAD);  // must never be read
    // Reference: every stride-1 window of the row, elements in order.
    for (int wi = 0; wi <= w - FW; wi++) begin
      for (int k = 0; k < FW; k++) begin
        exp_t t;
        t.d = d[wi + k];
        t.l = (k == FW - 1);
        exp_q.push_back(t);
      end
    end
    x0           = xfer_cnt;
    done_cyc     = -1;
    busy_at_done = 1'b0;

    cyc         = 0;
    start       = 1'b1;
    cfg_row_len = LW'(w);
    out_ready   = 1'b1;
    force_empty = 1'b0;
    step();
    start       = 1'b0;
    cfg_row_len = LW'(1);  // must have been latched at start

    for (int c = 1; c < 3000 && done_cyc < 0; c++) begin
      cyc = c;
      case (ready_mode)
        1:       out_ready = !((c % 4 == 1) || (c % 4 == 2));
        2:       out_ready = ($urandom_range(0, 9) < 7);
        default: out_ready = 1'b1;
      endcase
      case (empty_mode)
        1:       force_empty = ((c >= 2 && c <= 5) || (c >= 11 && c <= 14));
        2:       force_empty = ($urandom_range(0, 4) == 0);
        default: force_empty = 1'b0;
      endcase
      start = (c == start2_at);
      if (start) cfg_row_len = LW'(3);
      rst = (c == rst_at);
      step();
      start = 1'b0;
      if (c == rst_at) begin
        rst = 1'b0;
        exp_q.delete();
        cyc = c + 1;
        check_idle();
        return;
      end
      if (s_done) begin
        done_cyc     = c;
        busy_at_done = s_busy;
      end
    end

    if (done_cyc < 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL row_done_timeout: no row_done within budget, row length %0d", w);
    end else begin
      if (exp_done >= 0) check("done_cycle", done_cyc, exp_done);
      check("busy_in_done", busy_at_done, 1);
      cyc++;
      out_ready   = 1'b1;
      force_empty = 1'b0;
      step();
      check("busy_after_done", s_busy, 0);
      check("row_done_one_cycle", s_done, 0);
    end
    check("pop_count", pop_cyc.size(), w);
    check("unread_sentinel", fq.size(), 1);
    check("xfer_count", xfer_cnt - x0, (w - FW + 1) * FW);
    check("scoreboard_drained", exp_q.size(), 0);
    if (chk_pops) begin
      for (int k = 0; k < pop_cyc.size(); k++) begin
        exp_pc = (k < FW) ? k + 1 : FW + (k - FW + 1) * (FW + 1);
        check("pop_cycle", pop_cyc[k], exp_pc);
      end
    end
    exp_q.delete();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst            = 1'b1;
    start          = 1'b0;
    cfg_row_len    = '0;
    out_ready      = 1'b0;
    force_empty    = 1'b0;
    fifo_empty     = 1'b1;
    fifo_read_data = '0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_busy", busy, 0);
    check("reset_out_valid", out_valid, 0);
    check("reset_rd_en", fifo_read_en, 0);
    @(negedge clk);
    rst = 1'b0;
    fq.push_back(16'h0007);  // non-empty FIFO must still not be read in IDLE
    check_idle();
    fq.delete();

    // Basic row, W=5, no stalls.
    run_row(5, 0, 0, 0, -1, -1, 15, 1'b1);
    // FIFO empty 4 cycles in FILL and 4 in SHIFT: +8 cycles.
    run_row(5, 0, 0, 1, -1, -1, 23, 1'b0);
    // out_ready pattern 1,0,0,1.
    run_row(5, 0, 1, 0, -1, -1, -1, 1'b0);
    // Single window.
    run_row(3, 0, 0, 0, -1, -1, 7, 1'b1);

    // Too-short row rejected.
    fq.delete();
    fq.push_back(16'h0055);
    pop_cyc.delete();
    out_ready   = 1'b1;
    force_empty = 1'b0;
    cyc         = 0;
    start       = 1'b1;
    cfg_row_len = LW'(2);
    step();
    start = 1'b0;
    cyc   = 1;
    step();
    check("cfg_err_pulse", s_err, 1);
    check("cfg_err_busy", s_busy, 0);
    cyc = 2;
    step();
    check("cfg_err_single", s_err, 0);
    check("cfg_err_busy_after", s_busy, 0);
    check("cfg_err_no_pop", pop_cyc.size(), 0);

    // Start during a running row is ignored.
    run_row(5, 0, 0, 0, -1, 5, 15, 1'b0);
    // Reset in cycle 9, then an identical row replays exactly.
    run_row(5, 0, 0, 0, 9, -1, -1, 1'b0);
    run_row(5, 0, 0, 0, -1, -1, 15, 1'b1);

    // Random rows with random stalls.
    for (int r = 0; r < 8; r++) begin
      run_row($urandom_range(3, 12), 1, 2, 2, -1, -1, -1, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ifmap_window_feeder.md
Name: ifmap_window_feeder

Overview:
- PE-side consumer of the ifmap FIFO.
- Pops ifmap row elements from the FIFO and holds a FILT_W-deep sliding window in registers.
- For each output column, replays the window elements in order to the MAC datapath through a valid/ready handshake.
- Between windows it pops exactly one new element, so each ifmap element is read from the FIFO once per row (stride 1).

Parameters:
DATA_WIDTH, 16, element bitwidth
FILT_W, 3, filter row width S; window depth, must be >= 2
LEN_W, 8, width of the row-length config field

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  begin processing one ifmap row; sampled only in IDLE
cfg_row_len  input  LEN_W  ifmap row length W; latched on accepted start
fifo_empty  input  1  FIFO empty flag
fifo_read_data  input  DATA_WIDTH  FIFO head data, valid while fifo_empty=0
fifo_read_en  output  1  pop request; combinational
out_data  output  DATA_WIDTH  window element to MAC
out_valid  output  1  out_data valid
out_ready  input  1  MAC accepts out_data
out_last  output  1  marks the final (FILT_W-th) element of a window
busy  output  1  high in any state except IDLE
row_done  output  1  one-cycle pulse when a row completes
cfg_err  output  1  one-cycle pulse when start is rejected

Behaviour:
- Reset values: state=IDLE; all counters 0; window registers 0; fifo_read_en=0, out_valid=0, out_last=0, busy=0, row_done=0, cfg_err=0.
- rst mid-row aborts immediately; no FIFO pop or output transfer occurs in the reset cycle.
- FIFO contract:
  - fifo_read_en = 0 whenever fifo_empty=1.
  - A pop is fifo_read_en=1 with fifo_empty=0; fifo_read_data is captured in that same cycle (first-word fall-through).
- Latched at start: row_len = cfg_row_len; num_win = row_len - FILT_W + 1.
- IDLE:
  - start with cfg_row_len < FILT_W: pulse cfg_err next cycle, stay in IDLE.
  - start otherwise: latch config, go to FILL; clear fill_cnt, emit_idx, win_cnt.
- FILL:
  - fifo_read_en = !fifo_empty.
  - Each pop writes win[fill_cnt] and increments fill_cnt.
  - After the FILT_W-th pop, go to EMIT.
  - Stall indefinitely while the FIFO is empty.
- EMIT:
  - out_valid=1; out_data = win[emit_idx] (combinational mux); out_last = (emit_idx == FILT_W-1).
  - On transfer (out_valid & out_ready), emit_idx increments.
  - On the out_last transfer, emit_idx returns to 0. If win_cnt == num_win-1, go to DONE; else go to SHIFT.
  - out_data, out_last and emit_idx stay stable while out_ready=0.
  - fifo_read_en=0.
- SHIFT:
  - fifo_read_en = !fifo_empty.
  - On pop: win[i] <= win[i+1] for i < FILT_W-1; win[FILT_W-1] <= fifo_read_data; win_cnt increments; go to EMIT.
  - out_valid=0.
- DONE: row_done=1 for exactly one cycle, then IDLE. A start in DONE is ignored.
- start while busy is ignored and has no effect on config.
- Pop count per row is exactly row_len; transfer count per row is exactly num_win × FILT_W.
- Minimum latency with no stalls: FILT_W + num_win×FILT_W + (num_win−1) + 1 cycles after start acceptance.
- Counter widths:
  - fill_cnt and emit_idx: $clog2(FILT_W+1) bits.
  - win_cnt: LEN_W bits.
  - No wrap is possible because row_len ≤ 2^LEN_W−1.

Test Plan:
- FILT_W=3, W=5, FIFO preloaded 1..5, out_ready=1, start @cycle0:
  - pops in cycles 1–3 and 7, 11;
  - outputs 1,2,3 | 2,3,4 | 3,4,5 in cycles 4–6, 8–10, 12–14, with out_last on 3, 4, 5;
  - row_done in cycle 15; busy falls in cycle 16.
- Same stimulus, FIFO empty for 4 cycles during FILL and during SHIFT:
  - fifo_read_en stays 0 while empty;
  - output sequence unchanged; completion delayed by exactly 8 cycles.
- out_ready toggling 1,0,0,1 during EMIT:
  - out_data and out_last are held through the stall;
  - no duplicated or skipped element; 9 transfers total.
- W=3 (a single window):
  - 3 pops, outputs 1,2,3, then row_done; no SHIFT state entered.
- W=2 start:
  - cfg_err pulses one cycle; no pop; busy stays 0.
  - A second start during a running row is ignored.
- rst asserted in cycle 9 of scenario 1:
  - next cycle state is IDLE with all outputs 0;
  - a new start with a refilled FIFO 1..5 reproduces scenario 1 exactly.
